axis_wrr_scheduler: RTL and testbench
=====================================

Name: axis_wrr_scheduler

Overview:
Packet-granular weighted round-robin scheduler that shares one AXI-stream output among PORTS requesters. Each grant lasts for a whole number of packets, up to that port's configured weight, before ownership rotates to the next port. It drives the select and grant lines of the downstream stream mux. It observes the output-side handshake (tvalid/tready/tlast) to find packet boundaries, and never cuts a packet.

Parameters:
PORTS, 4, number of requesters (2..32)
WEIGHT_WIDTH, 4, width of each per-port weight (packets per turn)
ARB_LSB_HIGH_PRIORITY, 1, rotation order: 1 = search ascending index from pointer, 0 = descending

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
request  input  PORTS  per-port packet pending (the port's s_axis_tvalid)
weight  input  PORTS*WEIGHT_WIDTH  per-port weight, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 = port disabled
xfer_valid  input  1  shared output tvalid
xfer_ready  input  1  shared output tready
xfer_last  input  1  shared output tlast
grant  output  PORTS  one-hot grant
grant_valid  output  1  grant is active
grant_encoded  output  $clog2(PORTS)  index of granted port
credit  output  WEIGHT_WIDTH  packets remaining in the current turn
in_packet  output  1  a packet is partially transferred

Behaviour:
- Reset (asynchronous, active-high): grant=0, grant_valid=0, grant_encoded=0, credit=0, in_packet=0, state=IDLE, rotation pointer=0. All registers are asynchronous-reset.
- Eligible port: request[i]=1 and weight[i]!=0.
- States: IDLE and GRANT.
- IDLE:
  - If any port is eligible, pick the first eligible port strictly after the pointer in rotation order, wrapping around. The pointer port itself is last in the search.
  - Next cycle: state=GRANT, grant_valid=1, grant=one-hot(sel), grant_encoded=sel, credit=weight[sel] sampled at that edge, pointer=sel.
  - Latency from request to grant_valid is 1 cycle.
- Beat: xfer_valid & xfer_ready & grant_valid. Handshakes while grant_valid=0 are ignored.
- GRANT, beat with xfer_last=0: in_packet<=1.
- GRANT, beat with xfer_last=1: in_packet<=0, credit<=credit-1.
  - If credit was 1: go to IDLE, grant<=0, grant_valid<=0. grant_encoded holds its value.
- GRANT, forfeit: in_packet=0, no beat this cycle, and request[grant_encoded]=0. Go to IDLE and drop the grant; remaining credit is discarded.
- A single-beat packet (xfer_last on the first beat) counts as one packet and is handled like any last beat.
- The release cycle always produces one idle cycle (grant_valid=0) before the next grant. Maximum throughput is one rotation per (packets + 1) cycles of overhead.
- Weight changes during GRANT do not affect the current turn. They take effect at the next grant.
- A port whose weight becomes 0 while granted keeps its grant until its credit is exhausted or it forfeits.
- No eligible port in IDLE: stay in IDLE, outputs unchanged (grant_valid=0).
- If only one port is eligible, it is re-granted after each release, with the one-cycle gap.
- Simultaneous last beat and request drop: last-beat handling takes priority.
- Reset asserted mid-packet: immediate return to reset values. The bench must not expect the packet to complete.
- credit never underflows: a decrement happens only on a last beat in GRANT, and credit>=1 there.

Test Plan:
- Weights {1,1,1,1}, all requests held high, 1-beat packets, xfer_ready=1 -> grant_encoded sequence 1,2,3,0,1..., each grant 1 cycle followed by 1 idle cycle.
- Weights {2,1,0,3}, all requests high, 3-beat packets -> port1: 1 packet, port3: 3 packets, port0: 2 packets, then repeat; port2 is never granted; credit counts 3,2,1 during port3's turn.
- Port0 weight 4, request drops after its 2nd packet while in_packet=0 -> grant released next cycle, credit 2 discarded, port1 granted 2 cycles after the drop.
- xfer_ready=0 stalling a last beat for 5 cycles with weight 1 -> grant held for the whole stall, released only on the cycle after the accepted last beat.
- Assert rst for 1 cycle while in_packet=1 and credit=2 -> all outputs 0 immediately (asynchronous); first grant after release goes to port1 (pointer reset to 0).
- Change weight[1] from 1 to 3 while port1 is granted -> current turn ends after 1 packet; port1's next turn lasts 3 packets.

Source files
------------

// File: rtl/axis_wrr_scheduler.sv
// Packet-granular weighted round-robin scheduler for one shared AXI-stream output.
// A port keeps the grant for up to weight[i] whole packets, then ownership rotates.
module axis_wrr_scheduler #(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_WIDTH          = 4,
  parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                          xfer_valid,
  input  logic                          xfer_ready,
  input  logic                          xfer_last,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic [WEIGHT_WIDTH-1:0]       credit,
  output logic                          in_packet
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [WEIGHT_WIDTH-1:0] weight_arr [PORTS];
  logic [PORTS-1:0]        eligible;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic                    beat;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORTS; i++) begin
      weight_arr[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      eligible[i]   = request[i] && (weight_arr[i] != '0);
    end
  end

  // grant_encoded doubles as the rotation pointer: it always holds the last granted port
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= PORTS; k++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0)
        cand = (int'(grant_encoded) + k) % PORTS;
      else
        cand = (int'(grant_encoded) + PORTS - k) % PORTS;
      if (!sel_found && eligible[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign beat = xfer_valid && xfer_ready && grant_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      credit        <= '0;
      in_packet     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state         <= GRANT;
            grant         <= PORTS'(1) << sel_idx;
            grant_valid   <= 1'b1;
            grant_encoded <= sel_idx;
            credit        <= weight_arr[sel_idx];
          end
        end
        GRANT: begin
          if (beat) begin
            if (xfer_last) begin
              in_packet <= 1'b0;
              credit    <= credit - 1'b1;
              if (credit == WEIGHT_WIDTH'(1)) begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
              end
            end else begin
              in_packet <= 1'b1;
            end
          end else if (!in_packet && !request[grant_encoded]) begin
            // owner went quiet between packets: give up the rest of its turn
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            credit      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wrr_scheduler.sv
// Self-checking bench for axis_wrr_scheduler: a turn-level model checked every cycle,
// plus directed scenarios whose grant order, packet counts and timing are pinned by hand.
module tb_axis_wrr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  request = '0;
  logic [15:0] weight = '0;
  logic        xfer_valid = 1'b0;
  logic        xfer_ready = 1'b1;
  logic        xfer_last = 1'b0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic [3:0]  credit;
  logic        in_packet;

  int n_checks = 0;
  int n_fail = 0;

  axis_wrr_scheduler #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_LSB_HIGH_PRIORITY(1)) dut (
    .clk(clk), .rst(rst), .request(request), .weight(weight),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_last(xfer_last),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .credit(credit), .in_packet(in_packet)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs only change 2 time units after a rising edge, so every process sees them stable.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int pkt_len = 1;

  task automatic applyStimulus(input logic [3:0] req, input int w0, input int w1,
                               input int w2, input int w3, input int plen);
    pkt_len = plen;
    weight  = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    request = req;
  endtask

  // Source side of the mux: the owner streams fixed-length packets while it requests.
  int beat_cnt = 0;
  int lasts_total = 0;

  always @(negedge clk) begin
    if (grant_valid === 1'b1 && request[grant_encoded] === 1'b1) begin
      xfer_valid = 1'b1;
      xfer_last  = (beat_cnt == pkt_len - 1);
    end else begin
      xfer_valid = 1'b0;
      xfer_last  = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) beat_cnt = 0;
    else if (xfer_valid && xfer_ready) begin
      if (xfer_last) begin
        beat_cnt = 0;
        lasts_total++;
      end else begin
        beat_cnt++;
      end
    end
  end

  // Model: owner (-1 = nobody), packets left in the turn, mid-packet flag, last granted port.
  int m_owner = -1;
  int m_credit = 0;
  int m_inpkt = 0;
  int m_last = 0;

  function automatic int pick(input int after);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (after + k) % 4;
      if (request[2'(c)] && weight[c*4 +: 4] != 4'd0) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int p;
    if (rst) begin
      m_owner = -1; m_credit = 0; m_inpkt = 0; m_last = 0;
    end else if (m_owner < 0) begin
      p = pick(m_last);
      if (p >= 0) begin
        m_owner  = p;
        m_last   = p;
        m_credit = int'(weight[p*4 +: 4]);
      end
    end else if (xfer_valid && xfer_ready) begin
      if (xfer_last) begin
        m_inpkt  = 0;
        m_credit = m_credit - 1;
        if (m_credit == 0) m_owner = -1;
      end else begin
        m_inpkt = 1;
      end
    end else if (m_inpkt == 0 && !request[2'(m_owner)]) begin
      m_owner  = -1;
      m_credit = 0;
    end
  end

  always @(negedge clk) begin
    checkOutput("grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
    checkOutput("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    checkOutput("grant_encoded", int'(grant_encoded), m_last);
    checkOutput("credit", int'(credit), m_credit);
    checkOutput("in_packet", int'(in_packet), m_inpkt);
  end

  // Turn log taken from the DUT: port, packets sent, cycles held, credit at start.
  int q_port[$], q_pkts[$], q_dur[$], q_cred[$];
  int cur_port, cur_start, cur_dur, cur_cred;
  bit gv_prev = 1'b0;

  always @(negedge clk) begin
    if (grant_valid === 1'b1 && !gv_prev) begin
      cur_port = int'(grant_encoded); cur_start = lasts_total;
      cur_dur = 0; cur_cred = int'(credit);
    end
    if (grant_valid === 1'b1) cur_dur++;
    if (grant_valid !== 1'b1 && gv_prev) begin
      q_port.push_back(cur_port); q_pkts.push_back(lasts_total - cur_start);
      q_dur.push_back(cur_dur); q_cred.push_back(cur_cred);
    end
    gv_prev = (grant_valid === 1'b1);
  end

  task automatic do_reset();
    request    = '0;
    xfer_ready = 1'b1;
    rst        = 1'b1;
    step(2);
    rst = 1'b0;
    q_port.delete(); q_pkts.delete(); q_dur.delete(); q_cred.delete();
  endtask

  int exp1_port[5] = '{1, 2, 3, 0, 1};
  int exp2_port[6] = '{1, 3, 0, 1, 3, 0};
  int exp2_pkts[3] = '{1, 3, 2};
  int exp2_dur[3]  = '{3, 9, 6};
  int exp6_port[3] = '{1, 0, 1};
  int exp6_pkts[3] = '{1, 1, 3};

  initial begin
    rst = 1'b1;
    do_reset();
    checkOutput("reset_grant_valid", int'(grant_valid), 0);
    checkOutput("reset_credit", int'(credit), 0);

    $display("[TB] equal weights, single-beat packets");
    applyStimulus(4'b1111, 1, 1, 1, 1, 1);
    step(11);
    checkOutput("t1_turns", q_port.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t1_port%0d", i), q_port[i], exp1_port[i]);
      checkOutput($sformatf("t1_dur%0d", i), q_dur[i], 1);
    end

    $display("[TB] weights 2,1,0,3 with three-beat packets");
    do_reset();
    applyStimulus(4'b1111, 2, 1, 0, 3, 3);
    step(44);
    checkOutput("t2_turns", q_port.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t2_port%0d", i), q_port[i], exp2_port[i]);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_pkts%0d", i), q_pkts[i], exp2_pkts[i]);
      checkOutput($sformatf("t2_cred%0d", i), q_cred[i], exp2_pkts[i]);
      checkOutput($sformatf("t2_dur%0d", i), q_dur[i], exp2_dur[i]);
    end

    $display("[TB] owner drops request between packets");
    do_reset();
    applyStimulus(4'b0001, 4, 1, 0, 0, 1);
    step(3);
    checkOutput("t3_credit_before_drop", int'(credit), 2);
    request = 4'b0010;
    step(1);
    checkOutput("t3_released", int'(grant_valid), 0);
    checkOutput("t3_credit_discarded", int'(credit), 0);
    checkOutput("t3_model_owner", m_owner, -1);
    checkOutput("t3_model_credit", m_credit, 0);
    step(1);
    checkOutput("t3_next_valid", int'(grant_valid), 1);
    checkOutput("t3_next_port", int'(grant_encoded), 1);
    checkOutput("t3_port0_pkts", q_pkts[0], 2);
    checkOutput("t3_port0_dur", q_dur[0], 3);

    $display("[TB] stalled last beat");
    do_reset();
    xfer_ready = 1'b0;
    applyStimulus(4'b0001, 1, 0, 0, 0, 1);
    step(1);
    checkOutput("t4_grant", int'(grant), 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput($sformatf("t4_hold%0d", i), int'(grant_valid), 1);
    end
    xfer_ready = 1'b1;
    step(1);
    checkOutput("t4_release", int'(grant_valid), 0);
    checkOutput("t4_release_credit", int'(credit), 0);
    step(1);
    checkOutput("t4_regrant", int'(grant_valid), 1);
    checkOutput("t4_regrant_port", int'(grant_encoded), 0);

    $display("[TB] asynchronous reset mid-packet");
    do_reset();
    applyStimulus(4'b0010, 2, 2, 2, 0, 3);
    step(2);
    checkOutput("t5_in_packet", int'(in_packet), 1);
    checkOutput("t5_credit", int'(credit), 2);
    request = 4'b0111;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_grant", int'(grant), 0);
    checkOutput("t5_async_valid", int'(grant_valid), 0);
    checkOutput("t5_async_enc", int'(grant_encoded), 0);
    checkOutput("t5_async_credit", int'(credit), 0);
    checkOutput("t5_async_inpkt", int'(in_packet), 0);
    checkOutput("t5_model_owner", m_owner, -1);
    step(1);
    rst = 1'b0;
    step(1);
    checkOutput("t5_first_grant_valid", int'(grant_valid), 1);
    checkOutput("t5_first_grant_port", int'(grant_encoded), 1);
    checkOutput("t5_model_port", m_last, 1);

    $display("[TB] weight change during a turn");
    do_reset();
    applyStimulus(4'b0011, 1, 1, 0, 0, 2);
    step(1);
    checkOutput("t6_start_credit", int'(credit), 1);
    weight[4 +: 4] = 4'd3;
    step(14);
    checkOutput("t6_turns", q_port.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6_port%0d", i), q_port[i], exp6_port[i]);
      checkOutput($sformatf("t6_pkts%0d", i), q_pkts[i], exp6_pkts[i]);
    end

    request = '0;
    step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
